// File: rtl/kyber_pwm_ctrl.sv
// Pointwise modular multiply sequencer for Kyber (q = 3329): streams N operand
// pairs from memories A/B through a multiply + Barrett-reduce pipeline into C.
module kyber_pwm_ctrl #(
  parameter int unsigned N  = 256,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [11:0]   scalar_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [11:0]   a_data_i,
  input  logic [11:0]   b_data_i,
  output logic          we_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [11:0]   wr_data_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [AW-1:0] LAST      = AW'(N - 1);
  localparam logic [11:0]   Q         = 12'd3329;
  localparam logic [38:0]   BARRETT_M = 39'd20158;  // floor(2^26 / q)

  // red_K: Barrett reduction of a 24-bit product (< q^2) into [0, q-1].
  // The quotient estimate undershoots by at most 2, hence two corrections.
  function automatic logic [11:0] red_k(input logic [23:0] p);
    logic [12:0] t;
    logic [24:0] tq;
    logic [13:0] r;
    t  = 13'(({15'd0, p} * BARRETT_M) >> 26);
    tq = {12'd0, t} * 25'(Q);
    r  = 14'({1'b0, p} - tq);
    if (r >= 14'(Q)) r = r - 14'(Q);
    if (r >= 14'(Q)) r = r - 14'(Q);
    return 12'(r);
  endfunction

  state_t        state, state_next;
  logic          run_mode, run_mode_next;
  logic [11:0]   run_scalar, run_scalar_next;
  logic          busy_next, done_next, rd_en_next;
  logic [AW-1:0] rd_addr_next;

  logic          v0, v1;
  logic [AW-1:0] addr0, addr1;
  logic [23:0]   prod;
  logic [11:0]   operand;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      run_mode   <= 1'b0;
      run_scalar <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rd_en_o    <= 1'b0;
      rd_addr_o  <= '0;
    end else begin
      state      <= state_next;
      run_mode   <= run_mode_next;
      run_scalar <= run_scalar_next;
      busy_o     <= busy_next;
      done_o     <= done_next;
      rd_en_o    <= rd_en_next;
      rd_addr_o  <= rd_addr_next;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_next      = state;
    run_mode_next   = run_mode;
    run_scalar_next = run_scalar;
    rd_en_next      = 1'b0;
    rd_addr_next    = rd_addr_o;
    done_next       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next      = READ;
          run_mode_next   = mode_i;
          run_scalar_next = scalar_i;
          rd_en_next      = 1'b1;
          rd_addr_next    = '0;
        end
      end
      READ: begin
        if (rd_addr_o == LAST) begin
          state_next = DRAIN;
        end else begin
          rd_en_next   = 1'b1;
          rd_addr_next = rd_addr_o + AW'(1);
        end
      end
      DRAIN: begin
        if (!v0 && !v1) begin
          state_next = FIN;
          done_next  = 1'b1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_comb begin
    operand = run_mode ? run_scalar : b_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      prod      <= '0;
      we_o      <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      v0    <= rd_en_o;
      addr0 <= rd_addr_o;
      v1    <= v0;
      addr1 <= addr0;
      if (v0) prod <= {12'd0, a_data_i} * {12'd0, operand};
      we_o <= v1;
      if (v1) begin
        wr_addr_o <= addr1;
        wr_data_o <= red_k(prod);
      end
    end
  end

endmodule

// File: tb/tb_kyber_pwm_ctrl.sv
// Self-checking bench: a small (N=4) instance for cycle-exact timing and a
// full-size (N=256) instance for randomised arithmetic against a mod-q model.
module tb_kyber_pwm_ctrl;

  localparam int SN  = 4;
  localparam int BN  = 256;
  localparam int SAW = 2;
  localparam int BAW = 8;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           s_start, s_mode, s_busy, s_done, s_rd_en, s_we;
  logic [11:0]    s_scalar, s_a, s_b, s_wr_data;
  logic [SAW-1:0] s_rd_addr, s_wr_addr;
  logic           b_start, b_mode, b_busy, b_done, b_rd_en, b_we;
  logic [11:0]    b_scalar, b_a, b_b, b_wr_data;
  logic [BAW-1:0] b_rd_addr, b_wr_addr;

  kyber_pwm_ctrl #(.N(SN)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .mode_i(s_mode),
    .scalar_i(s_scalar), .busy_o(s_busy), .done_o(s_done), .rd_en_o(s_rd_en),
    .rd_addr_o(s_rd_addr), .a_data_i(s_a), .b_data_i(s_b), .we_o(s_we),
    .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data)
  );

  kyber_pwm_ctrl #(.N(BN)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .mode_i(b_mode),
    .scalar_i(b_scalar), .busy_o(b_busy), .done_o(b_done), .rd_en_o(b_rd_en),
    .rd_addr_o(b_rd_addr), .a_data_i(b_a), .b_data_i(b_b), .we_o(b_we),
    .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data)
  );

  logic [11:0] sa [SN];
  logic [11:0] sb [SN];
  logic [11:0] sc [SN];
  logic [11:0] ba [BN];
  logic [11:0] bb [BN];
  logic [11:0] bc [BN];
  int s_writes = 0, s_dones = 0, b_writes = 0, b_dones = 0;

  initial begin
    s_a = '0; s_b = '0; b_a = '0; b_b = '0;
  end

  always @(posedge clk) begin
    if (s_rd_en) begin
      s_a <= sa[s_rd_addr];
      s_b <= sb[s_rd_addr];
    end
    if (s_we) begin
      sc[s_wr_addr] <= s_wr_data;
      s_writes++;
    end
    if (s_done) s_dones++;
    if (b_rd_en) begin
      b_a <= ba[b_rd_addr];
      b_b <= bb[b_rd_addr];
    end
    if (b_we) begin
      bc[b_wr_addr] <= b_wr_data;
      b_writes++;
    end
    if (b_done) b_dones++;
  end

  int checks = 0;
  int failures = 0;
  int w0, d0, done_cyc;
  logic [11:0] scal;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mulmod(input int a, input int b);
    return (a * b) % 3329;
  endfunction

  // Expected port activity r cycles after the cycle in which start was sampled.
  task automatic check_small_cycle(input int r);
    bit rd, we;
    rd = (r >= 1 && r <= SN);
    we = (r >= 4 && r <= SN + 3);
    check_eq($sformatf("s_rd_en@%0d", r), s_rd_en, rd);
    if (rd) check_eq($sformatf("s_rd_addr@%0d", r), s_rd_addr, r - 1);
    check_eq($sformatf("s_we@%0d", r), s_we, we);
    if (we) check_eq($sformatf("s_wr_addr@%0d", r), s_wr_addr, r - 4);
    check_eq($sformatf("s_done@%0d", r), s_done, r == SN + 4);
    check_eq($sformatf("s_busy@%0d", r), s_busy, r >= 1 && r <= SN + 4);
  endtask

  task automatic small_run(input bit mode, input logic [11:0] scalar, input bit perturb);
    @(negedge clk);
    s_start  = 1'b1;
    s_mode   = mode;
    s_scalar = scalar;
    for (int c = 1; c <= SN + 6; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (perturb && c == 2) begin
        s_mode   = 1'b0;
        s_scalar = 12'd5;
      end
      check_small_cycle(c);
    end
  endtask

  task automatic check_small_mem(input bit mode, input int scalar);
    for (int i = 0; i < SN; i++)
      check_eq($sformatf("s_c[%0d]", i), sc[i],
               mode ? mulmod(sa[i], scalar) : mulmod(sa[i], sb[i]));
  endtask

  task automatic big_run(input bit mode, input logic [11:0] scalar);
    for (int i = 0; i < BN; i++) bc[i] = 12'hFFF;
    w0 = b_writes;
    d0 = b_dones;
    done_cyc = -1;
    @(negedge clk);
    b_start  = 1'b1;
    b_mode   = mode;
    b_scalar = scalar;
    for (int c = 1; c <= BN + 20; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_done && done_cyc < 0) done_cyc = c;
    end
    check_eq("b_done_cycle", done_cyc, BN + 4);
    check_eq("b_writes", b_writes - w0, BN);
    check_eq("b_dones", b_dones - d0, 1);
    for (int i = 0; i < BN; i++)
      check_eq($sformatf("b_c[%0d]", i), bc[i],
               mode ? mulmod(ba[i], scalar) : mulmod(ba[i], bb[i]));
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_scalar = '0;
    b_start = 1'b0; b_mode = 1'b0; b_scalar = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", s_busy, 0);
    check_eq("rst_done", s_done, 0);
    check_eq("rst_rd_en", s_rd_en, 0);
    check_eq("rst_we", s_we, 0);
    check_eq("rst_rd_addr", s_rd_addr, 0);
    check_eq("rst_wr_addr", s_wr_addr, 0);
    check_eq("rst_wr_data", s_wr_data, 0);
    check_eq("rst_b_busy", b_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed mode 0 vector with full timing
    sa[0] = 12'd3328; sa[1] = 12'd2;    sa[2] = 12'd0;  sa[3] = 12'd1234;
    sb[0] = 12'd3328; sb[1] = 12'd1665; sb[2] = 12'd77; sb[3] = 12'd1;
    for (int i = 0; i < SN; i++) sc[i] = 12'hFFF;
    w0 = s_writes; d0 = s_dones;
    small_run(1'b0, 12'd0, 1'b0);
    check_eq("t1_c0", sc[0], 1);
    check_eq("t1_c1", sc[1], 1);
    check_eq("t1_c2", sc[2], 0);
    check_eq("t1_c3", sc[3], 1234);
    check_small_mem(1'b0, 0);
    check_eq("t1_writes", s_writes - w0, SN);
    check_eq("t1_dones", s_dones - d0, 1);

    // Scalar mode, B ignored, inputs changed mid-run
    sa[0] = 12'd3000; sa[1] = 12'd3328;
    sa[2] = 12'($urandom_range(3328)); sa[3] = 12'($urandom_range(3328));
    for (int i = 0; i < SN; i++) begin
      sb[i] = 12'hFFF;
      sc[i] = 12'hFFF;
    end
    small_run(1'b1, 12'd17, 1'b1);
    check_eq("t2_c0", sc[0], 1065);
    check_eq("t2_c1", sc[1], 3312);
    check_small_mem(1'b1, 17);

    // start held high: exactly two back-to-back runs
    for (int i = 0; i < SN; i++) begin
      sa[i] = 12'($urandom_range(3328));
      sb[i] = 12'($urandom_range(3328));
      sc[i] = 12'hFFF;
    end
    w0 = s_writes; d0 = s_dones;
    @(negedge clk);
    s_start = 1'b1;
    s_mode  = 1'b0;
    for (int c = 1; c <= 2 * SN + 12; c++) begin
      @(negedge clk);
      if (c == 2 * SN + 10) s_start = 1'b0;
      check_small_cycle(c >= SN + 5 ? c - (SN + 5) : c);
    end
    check_eq("t3_writes", s_writes - w0, 2 * SN);
    check_eq("t3_dones", s_dones - d0, 2);
    check_small_mem(1'b0, 0);

    // Reset in cycle 3 of a run abandons it
    for (int i = 0; i < SN; i++) begin
      sa[i] = 12'($urandom_range(3328));
      sb[i] = 12'($urandom_range(3328));
      sc[i] = 12'hFFF;
    end
    w0 = s_writes; d0 = s_dones;
    @(negedge clk);
    s_start = 1'b1;
    s_mode  = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t4_busy", s_busy, 0);
    check_eq("t4_rd_en", s_rd_en, 0);
    check_eq("t4_rd_addr", s_rd_addr, 0);
    check_eq("t4_we", s_we, 0);
    check_eq("t4_wr_addr", s_wr_addr, 0);
    check_eq("t4_wr_data", s_wr_data, 0);
    check_eq("t4_done", s_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SN + 8) @(negedge clk);
    check_eq("t4_no_writes", s_writes - w0, 0);
    check_eq("t4_no_done", s_dones - d0, 0);
    check_eq("t4_idle", s_busy, 0);
    w0 = s_writes; d0 = s_dones;
    small_run(1'b0, 12'd0, 1'b0);
    check_small_mem(1'b0, 0);
    check_eq("t4_rerun_writes", s_writes - w0, SN);
    check_eq("t4_rerun_dones", s_dones - d0, 1);

    // Full-size randomised runs
    for (int i = 0; i < BN; i++) begin
      ba[i] = 12'($urandom_range(3328));
      bb[i] = 12'($urandom_range(3328));
    end
    ba[0] = 12'd3328; bb[0] = 12'd3328;
    ba[1] = 12'd0;    bb[BN-1] = 12'd3328;
    big_run(1'b0, 12'd0);
    scal = 12'($urandom_range(3328));
    big_run(1'b1, scal);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
